hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage MIPS core. It drives the write/flush controls of the PC and the IF/ID register, and the `enable_i` input of the ID/EX register, where a low level loads a bubble. It tracks in-flight destination registers in a 3-slot scoreboard (EX, MEM, WB) that mirrors what the ID/EX register actually captures. From that scoreboard it decides stalls for data hazards and squashes for control transfers resolved in EX.

## Interface
Parameters:
- `REG_AW`, 5, register address width.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `id_valid_i`  in  1  ID stage holds a valid instruction.
- `id_rs_i`  in  REG_AW  source register rs of the ID instruction.
- `id_rt_i`  in  REG_AW  source register rt of the ID instruction.
- `id_uses_rs_i`  in  1  ID instruction reads rs.
- `id_uses_rt_i`  in  1  ID instruction reads rt.
- `id_dst_i`  in  REG_AW  destination register of the ID instruction, already resolved through RegDst.
- `id_regwrite_i`  in  1  ID instruction writes the register file.
- `id_memread_i`  in  1  ID instruction is a load.
- `ex_redirect_i`  in  1  taken branch or jump resolved in EX this cycle.
- `pc_write_o`  out  1  PC update enable.
- `ifid_write_o`  out  1  IF/ID load enable.
- `ifid_flush_o`  out  1  IF/ID clear, which loads a NOP.
- `idex_enable_o`  out  1  drives ID/EX `enable_i`; 0 inserts a bubble.
- `stall_o`  out  1  data-hazard stall active this cycle.
- `stall_cnt_o`  out  CNT_W  saturating count of stall cycles.

## Operation
Scoreboard:
- Each slot holds {valid, dst, regwrite, memread}.
- At every posedge:
  - EX slot <= ID info if `idex_enable_o`=1, else all zero.
  - MEM <= EX.
  - WB <= MEM.
- A slot is a hazard source only if valid=1, regwrite=1 and dst≠0.
- A source operand matches a slot when its use flag is 1 and its register equals the slot's dst.

Hazard detection:
- With `HAZ_FORWARD_EN`: `hazard` = match against the EX slot with memread=1. This is a load-use hazard only.
- Without it: `hazard` = match against any of the EX, MEM or WB slots.
- `hazard` is qualified by `id_valid_i`.

Output decision, combinational from scoreboard and inputs, in priority order:
1. `ex_redirect_i`=1:
   - `pc_write_o`=1, `ifid_write_o`=1, `ifid_flush_o`=1, `idex_enable_o`=0, `stall_o`=0.
   - The ID instruction is squashed; the redirect overrides any hazard.
2. `hazard`=1:
   - `pc_write_o`=0, `ifid_write_o`=0, `ifid_flush_o`=0, `idex_enable_o`=0, `stall_o`=1.
3. Otherwise:
   - `pc_write_o`=1, `ifid_write_o`=1, `ifid_flush_o`=0, `stall_o`=0.
   - `idex_enable_o`=`id_valid_i`.

Stall counter:
- `stall_cnt_o` increments by 1 at each posedge where `stall_o`=1.
- It saturates at all-ones and never wraps.

## Timing
- Reset (`rst_n` low, asynchronous): scoreboard slots and `stall_cnt_o` clear to 0.
- While `rst_n` is low, all control outputs are forced to 0: `pc_write_o`, `ifid_write_o`, `ifid_flush_o`, `idex_enable_o`, `stall_o`.
- After release, outputs follow the decision rules from the first cycle.
- Reset asserted mid-stall aborts the stall; no state survives.
- Decision latency is 0 cycles (combinational). Scoreboard latency is 1 cycle per stage.
- Load-use with `HAZ_FORWARD_EN`: exactly 1 stall cycle. The bubble enters EX, the load moves to MEM, and the ID instruction issues next cycle.
- Without `HAZ_FORWARD_EN`, for a dependent instruction directly behind its producer:
  - 3 stall cycles, whether or not the producer is a load.
  - 2 stall cycles with one independent instruction in between.
  - 1 stall cycle with two in between.
  - The register file does not bypass, so the WB slot counts.
- Redirect during a stall: the redirect wins. The stalled ID instruction is squashed, and the counter does not increment that cycle.
- Back-to-back redirects: each one flushes; the scoreboard receives bubbles.
- `id_valid_i`=0: never a stall; a bubble enters EX.
- A destination of $0 never causes a stall.

## Configuration
- `HAZ_FORWARD_EN` defined: the EX/MEM/WB forwarding network exists downstream. Only load-use hazards against the EX slot stall.
- `HAZ_FORWARD_EN` undefined: there is no forwarding. Any RAW dependence on the EX, MEM or WB slots stalls until the producer has left WB.

## Test plan
- **Load-use, forwarding:** `lw $2` then `add $3,$2,$4`, with `HAZ_FORWARD_EN` -> one cycle with `stall_o`=1, `pc_write_o`=0 and `idex_enable_o`=0; the add issues next cycle; `stall_cnt_o`=1.
- **ALU RAW, forwarding:** `add $2` then `sub $5,$2,$1`, with `HAZ_FORWARD_EN` -> no stall; `stall_cnt_o` stays 0.
- **Same RAW, no forwarding:** macro undefined -> 3 consecutive stall cycles, then issue; `stall_cnt_o`=3.
- **$0 destination:** producer with dst=$0 and a consumer reading $0, macro undefined -> no stall.
- **Redirect over stall:** `ex_redirect_i`=1 in the same cycle as a load-use hazard -> `ifid_flush_o`=1, `pc_write_o`=1, `idex_enable_o`=0, `stall_o`=0; the counter is unchanged.
- **Reset mid-stall and saturation:**
  - Assert `rst_n`=0 in the middle of the 2nd stall cycle -> all outputs 0 immediately; after release the scoreboard is empty and there is no stall.
  - With `CNT_W`=4 and 20 stall cycles -> `stall_cnt_o`=15.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX/MEM/WB destination scoreboard, stall/flush decision, stall counter.
// Define HAZ_FORWARD_EN when the forwarding network exists; then only load-use against EX stalls.
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              ex_redirect_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_enable_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d;
  logic  hz_ex, hz_mem, hz_wb, hazard;

  // The WB slot is the end of the line; its load flag is carried only for symmetry.
  logic unused_wb_memread;
  assign unused_wb_memread = wb_q.memread;

  function automatic logic src_match(input slot_t s,
                                     input logic uses_rs, input logic [REG_AW-1:0] rs,
                                     input logic uses_rt, input logic [REG_AW-1:0] rt);
    logic live;
    live = s.valid && s.regwrite && (s.dst != '0);
    return live && ((uses_rs && (rs == s.dst)) || (uses_rt && (rt == s.dst)));
  endfunction

  always_comb begin
    hz_ex  = src_match(ex_q,  id_uses_rs_i, id_rs_i, id_uses_rt_i, id_rt_i);
    hz_mem = src_match(mem_q, id_uses_rs_i, id_rs_i, id_uses_rt_i, id_rt_i);
    hz_wb  = src_match(wb_q,  id_uses_rs_i, id_rs_i, id_uses_rt_i, id_rt_i);
`ifdef HAZ_FORWARD_EN
    hazard = id_valid_i && hz_ex && ex_q.memread;
`else
    hazard = id_valid_i && (hz_ex || hz_mem || hz_wb);
`endif
  end

  // NOTE: every output gets a default before the branches so no path leaves one unassigned (no latch).
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_enable_o = 1'b0;
    stall_o       = 1'b0;
    if (!rst_n) begin
      // Controls stay quiet for the whole reset window.
    end else if (ex_redirect_i) begin
      pc_write_o   = 1'b1;
      ifid_write_o = 1'b1;
      ifid_flush_o = 1'b1;
    end else if (hazard) begin
      stall_o = 1'b1;
    end else begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      idex_enable_o = id_valid_i;
    end
  end

  // EX mirrors what ID/EX captures: a bubble whenever the enable is low.
  always_comb begin
    ex_d = '0;
    if (idex_enable_o) begin
      ex_d.valid    = id_valid_i;
      ex_d.dst      = id_dst_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the EX->MEM->WB shift reads old values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_o <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed pipeline scenarios, expectations queued per cycle.
module tb_hazard_ctrl_unit;
  localparam int AW = 5;
  localparam int CW = 4;

  // Expected control vector order: {pc_write, ifid_write, ifid_flush, idex_enable, stall}
  localparam logic [4:0] RUN   = 5'b11010;
  localparam logic [4:0] IDLE  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00001;
  localparam logic [4:0] REDIR = 5'b11100;
  localparam logic [4:0] OFF   = 5'b00000;

`ifdef HAZ_FORWARD_EN
  localparam int ALU_STALLS  = 0;
  localparam int GAP1_STALLS = 0;
  localparam int LOAD_STALLS = 1;
  localparam int SAT_PAIRS   = 20;
`else
  localparam int ALU_STALLS  = 3;
  localparam int GAP1_STALLS = 2;
  localparam int LOAD_STALLS = 3;
  localparam int SAT_PAIRS   = 7;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          id_valid_i, id_uses_rs_i, id_uses_rt_i, id_regwrite_i, id_memread_i, ex_redirect_i;
  logic [AW-1:0] id_rs_i, id_rt_i, id_dst_i;
  logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_enable_o, stall_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .ex_redirect_i(ex_redirect_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_enable_o(idex_enable_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    string         name;
    logic [4:0]    ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt;
  event          sample_ev;

  always @(negedge clk_i) -> sample_ev;

  // Monitor: every sample point drains whatever the stimulus side has queued.
  initial begin : monitor
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_enable_o, stall_o};
        tests++;
        if (got !== e.ctrl || stall_cnt_o !== e.cnt) begin
          fails++;
          $display("FAIL %s: got ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                   e.name, got, stall_cnt_o, e.ctrl, e.cnt);
        end
      end
    end
  end

  task automatic expect_ctrl(input string name, input logic [4:0] ctrl);
    exp_t e;
    e.name = name;
    e.ctrl = ctrl;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    if (ctrl[0] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic apply(input string name, input logic v,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urs, input logic urt,
                       input logic [AW-1:0] dst, input logic rw, input logic mr,
                       input logic rd, input logic [4:0] ctrl);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_uses_rs_i  = urs;
    id_uses_rt_i  = urt;
    id_dst_i      = dst;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    ex_redirect_i = rd;
    expect_ctrl(name, ctrl);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Producer reads only $29 (never a tracked destination here).
  task automatic producer(input string name, input logic [AW-1:0] dst, input logic mr);
    next_cycle();
    apply(name, 1'b1, 5'd29, 5'd0, 1'b1, 1'b0, dst, 1'b1, mr, 1'b0, RUN);
  endtask

  // Consumer held in ID for n stall cycles, then issues.
  task automatic consumer(input string name, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      apply(name, 1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0, STALL);
    end
    next_cycle();
    apply(name, 1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0, RUN);
  endtask

  // Invalid ID slot whose fields would match pending producers: must never stall.
  task automatic drain(input string name, input logic [AW-1:0] rs);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      apply(name, 1'b0, rs, rs, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
    end
  endtask

  initial begin : stimulus
    exp_cnt = '0;
    rst_n   = 1'b0;
    #1;
    apply("reset_outputs", 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, OFF);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    apply("first_after_reset", 1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, RUN);

    // ALU RAW directly behind the producer: add $2 ; sub $5,$2,$1
    consumer("alu_raw", 5'd2, 5'd1, 5'd5, ALU_STALLS);
    drain("invalid_id", 5'd5);

    // $0 destination never creates a dependence
    producer("zero_dst_prod", 5'd0, 1'b0);
    consumer("zero_dst_use", 5'd0, 5'd0, 5'd6, 0);

    // One independent instruction between producer and consumer
    producer("gap1_prod", 5'd7, 1'b0);
    consumer("gap1_indep", 5'd9, 5'd10, 5'd8, 0);
    consumer("gap1_use", 5'd7, 5'd10, 5'd11, GAP1_STALLS);
    drain("drain_gap1", 5'd11);

    // Load-use: lw $12 ; add $13,$12,$4
    producer("lw_prod", 5'd12, 1'b1);
    consumer("load_use", 5'd12, 5'd4, 5'd13, LOAD_STALLS);
    drain("drain_load", 5'd13);

    // Redirect in the same cycle as a load-use hazard, then a second redirect
    producer("redir_prod", 5'd14, 1'b1);
    next_cycle();
    apply("redir_over_stall", 1'b1, 5'd14, 5'd4, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b1, REDIR);
    next_cycle();
    apply("redir_back2back", 1'b0, 5'd14, 5'd14, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, REDIR);
    drain("drain_redir", 5'd14);

    // Reset asserted in the middle of a stall cycle
    producer("rst_prod", 5'd16, 1'b1);
    next_cycle();
    apply("rst_stall1", 1'b1, 5'd16, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, STALL);
`ifndef HAZ_FORWARD_EN
    next_cycle();
    apply("rst_stall2", 1'b1, 5'd16, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, STALL);
`endif
    @(negedge clk_i);
    #2;
    rst_n   = 1'b0;
    exp_cnt = '0;
    expect_ctrl("reset_mid_stall", OFF);
    #1 -> sample_ev;
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    apply("no_stall_after_reset", 1'b1, 5'd16, 5'd4, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, RUN);
    drain("drain_reset", 5'd17);

    // Saturation: repeated load-use pairs push the 4-bit counter past 15
    for (int k = 0; k < SAT_PAIRS; k++) begin
      producer("sat_prod", 5'd20, 1'b1);
      consumer("sat_use", 5'd20, 5'd3, 5'd21, LOAD_STALLS);
    end
    drain("saturated", 5'd21);

    repeat (3) @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
